// File: rtl/shift_reg_input_pkg.sv
// Shared definitions for the serial shift-register link: FSM state encoding and default timing.
package shift_reg_input_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_CLK_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/shift_reg_input_clk_tick.sv
// Phase timer: o_tick is high on the last cycle of every CLK_DIV-cycle window.
module shift_clk_tick
    import shift_reg_input_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned      CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_d;

    // Tick is registered from the next count, so it lines up with cnt_q == LAST.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        if (i_restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q  <= '0;
            o_tick <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            o_tick <= tick_d;
        end
    end

endmodule

// File: rtl/shift_reg_input.sv
// Reader for a 74HC165-style PISO chain: loads, clocks out WIDTH bits MSB first,
// and presents the captured word with a one-cycle o_valid pulse.
module shift_reg_input
    import shift_reg_input_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable_toggle,
    input  logic             i_data_val,
    output logic             o_load_n,
    output logic             o_data_clock,
    output logic [WIDTH-1:0] o_value,
    output logic             o_valid,
    output logic             o_busy
);

    localparam int unsigned      BIT_W    = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] value_d;
    logic [1:0]       sync_q;
    logic             prev_toggle_q;
    logic             tick;
    logic             restart_c;
    logic             load_n_d, data_clock_d, valid_d, busy_d;

    // Divider is held cleared while idle so LOAD always starts on a full window.
    assign restart_c = (state_q == ST_IDLE) || (state_q == ST_DONE);

    shift_clk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_restart (restart_c),
        .o_tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        shift_d = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (i_enable_toggle != prev_toggle_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        shift_d = {shift_q[WIDTH-2:0], sync_q[1]};
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_DONE;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the next state so the registered pins match the state timing.
        load_n_d     = (state_d != ST_LOAD);
        data_clock_d = (state_d == ST_SHIFT) && phase_d;
        valid_d      = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
        value_d      = (state_d == ST_DONE) ? shift_q : o_value;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            bit_q         <= '0;
            phase_q       <= 1'b0;
            shift_q       <= '0;
            sync_q        <= '0;
            prev_toggle_q <= i_enable_toggle;
            o_load_n      <= 1'b1;
            o_data_clock  <= 1'b0;
            o_value       <= '0;
            o_valid       <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            phase_q       <= phase_d;
            shift_q       <= shift_d;
            sync_q        <= {sync_q[0], i_data_val};
            prev_toggle_q <= i_enable_toggle;
            o_load_n      <= load_n_d;
            o_data_clock  <= data_clock_d;
            o_value       <= value_d;
            o_valid       <= valid_d;
            o_busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_shift_reg_input.sv
// Bench for shift_reg_input: two instances (8/4 and 16/3) each reading a behavioural '165 chain.
module tb_shift_reg_input;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        tog_a = 1'b0, tog_b = 1'b0;
    logic [7:0]  pins_a = 8'h00;
    logic [15:0] pins_b = 16'h0000;
    logic [7:0]  chain_a;
    logic [15:0] chain_b;

    logic        load_n_a, dclk_a, valid_a, busy_a;
    logic [7:0]  value_a;
    logic        load_n_b, dclk_b, valid_b, busy_b;
    logic [15:0] value_b;

    int checks = 0, errors = 0;
    int low_a = 0, pul_a = 0, vld_a = 0;
    int low_b = 0, pul_b = 0, vld_b = 0;
    logic dclk_a_prev = 1'b0, dclk_b_prev = 1'b0;

    shift_reg_input #(.WIDTH(8), .CLK_DIV(4)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_enable_toggle(tog_a), .i_data_val(chain_a[7]),
        .o_load_n(load_n_a), .o_data_clock(dclk_a), .o_value(value_a),
        .o_valid(valid_a), .o_busy(busy_a)
    );

    shift_reg_input #(.WIDTH(16), .CLK_DIV(3)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_enable_toggle(tog_b), .i_data_val(chain_b[15]),
        .o_load_n(load_n_b), .o_data_clock(dclk_b), .o_value(value_b),
        .o_valid(valid_b), .o_busy(busy_b)
    );

    // '165 chain: asynchronous parallel load while SH/LD is low, shift toward QH on CLK rise.
    always @(posedge dclk_a or negedge load_n_a)
        if (!load_n_a) chain_a <= pins_a; else chain_a <= {chain_a[6:0], 1'b0};
    always @(posedge dclk_b or negedge load_n_b)
        if (!load_n_b) chain_b <= pins_b; else chain_b <= {chain_b[14:0], 1'b0};

    // Activity counters sampled on the clock edge (pre-update values).
    always @(posedge clk) begin
        if (load_n_a === 1'b0) low_a++;
        if (load_n_b === 1'b0) low_b++;
        if (dclk_a === 1'b1 && dclk_a_prev === 1'b0) pul_a++;
        if (dclk_b === 1'b1 && dclk_b_prev === 1'b0) pul_b++;
        if (valid_a === 1'b1) vld_a++;
        if (valid_b === 1'b1) vld_b++;
        dclk_a_prev = dclk_a;
        dclk_b_prev = dclk_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One capture on instance sel (0: 8-bit, 1: 16-bit); optional extra toggle at cycle retog.
    task automatic capture(input bit sel, input logic [15:0] pat, input int retog, input string tag);
        int w, cd, exp_lat, lat, l0, p0, v0;
        logic [15:0] exp_val, obs_val;
        w       = sel ? 16 : 8;
        cd      = sel ? 3 : 4;
        exp_lat = (2 + 2 * w) * cd;
        exp_val = sel ? pat : {8'h00, pat[7:0]};
        if (sel) pins_b = pat; else pins_a = pat[7:0];
        step(2);
        l0 = sel ? low_b : low_a;
        p0 = sel ? pul_b : pul_a;
        v0 = sel ? vld_b : vld_a;
        if (sel) tog_b = ~tog_b; else tog_a = ~tog_a;
        step(1);
        lat = 0;
        while (!(sel ? valid_b : valid_a) && lat < 400) begin
            step(1);
            lat++;
            if (lat == retog) begin
                if (sel) tog_b = ~tog_b; else tog_a = ~tog_a;
            end
        end
        obs_val = sel ? value_b : {8'h00, value_a};
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " value"}, 32'(obs_val), 32'(exp_val));
        step(1);
        obs_val = sel ? value_b : {8'h00, value_a};
        chk({tag, " value_hold"}, 32'(obs_val), 32'(exp_val));
        chk({tag, " valid_pulse_end"}, 32'(sel ? valid_b : valid_a), 32'(0));
        chk({tag, " busy_end"}, 32'(sel ? busy_b : busy_a), 32'(0));
        chk({tag, " load_low_cycles"}, 32'((sel ? low_b : low_a) - l0), 32'(cd));
        chk({tag, " clock_pulses"}, 32'((sel ? pul_b : pul_a) - p0), 32'(w));
        chk({tag, " valid_count"}, 32'((sel ? vld_b : vld_a) - v0), 32'(1));
    endtask

    initial begin
        int l0, v0;
        step(3);
        rst = 1'b0;
        chk("reset load_n", 32'(load_n_a), 32'(1));
        chk("reset data_clock", 32'(dclk_a), 32'(0));
        chk("reset value", 32'(value_a), 32'(0));
        chk("reset valid", 32'(valid_a), 32'(0));
        chk("reset busy", 32'(busy_a), 32'(0));
        chk("reset value_b", 32'(value_b), 32'(0));

        // Constant toggle input: no activity at all.
        l0 = low_a; v0 = vld_a;
        step(1000);
        chk("idle load_activity", 32'(low_a - l0), 32'(0));
        chk("idle valid_count", 32'(vld_a - v0), 32'(0));
        chk("idle busy", 32'(busy_a), 32'(0));

        // Reset 40 cycles into a capture: word discarded, no valid.
        pins_a = 8'h96;
        v0 = vld_a;
        tog_a = ~tog_a;
        step(41);
        chk("midreset busy_before", 32'(busy_a), 32'(1));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midreset load_n", 32'(load_n_a), 32'(1));
        chk("midreset data_clock", 32'(dclk_a), 32'(0));
        chk("midreset busy", 32'(busy_a), 32'(0));
        chk("midreset value", 32'(value_a), 32'(0));
        step(300);
        chk("midreset no_valid", 32'(vld_a - v0), 32'(0));
        chk("midreset busy_after", 32'(busy_a), 32'(0));

        capture(1'b0, 16'h00A5, -1, "basic_a5");
        capture(1'b0, 16'h0000, -1, "b2b_00");
        capture(1'b0, 16'h00FF, -1, "b2b_ff");

        // Toggle during a capture is dropped.
        capture(1'b0, 16'h003C, 20, "drop_3c");
        l0 = low_a; v0 = vld_a;
        step(300);
        chk("drop no_restart", 32'(low_a - l0), 32'(0));
        chk("drop no_valid", 32'(vld_a - v0), 32'(0));
        chk("drop busy", 32'(busy_a), 32'(0));

        capture(1'b1, 16'hBEEF, -1, "wide_beef");

        for (int i = 0; i < 6; i++) capture(1'b0, 16'($urandom()), -1, "rand_a");
        for (int i = 0; i < 3; i++) capture(1'b1, 16'($urandom()), -1, "rand_b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
